// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, RISC-V
// load/store funct3 codes and the access-size helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    // Bytes touched by an access; the low two funct3 bits select 1/2/4/8.
    function automatic logic [3:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_size = 4'd1;
            2'b01:   access_size = 4'd2;
            2'b10:   access_size = 4'd4;
            default: access_size = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a raw little-endian read according to the load funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [63:0] raw_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] data_o
);

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{56{raw_i[7]}},  raw_i[7:0]};
            F3_H:    data_o = {{48{raw_i[15]}}, raw_i[15:0]};
            F3_W:    data_o = {{32{raw_i[31]}}, raw_i[31:0]};
            F3_D:    data_o = raw_i;
            F3_BU:   data_o = {56'd0, raw_i[7:0]};
            F3_HU:   data_o = {48'd0, raw_i[15:0]};
            F3_WU:   data_o = {32'd0, raw_i[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory answering one MEM-stage load/store at a time,
// with a fixed LATENCY wait and a single-cycle response pulse.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 512,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        write_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [2:0]  f3_q;

    logic [63:0] rdata_q;
    logic        err_q;
    logic [7:0]  mem_q [DEPTH_BYTES];

    logic        accept;
    logic        enter_resp;
    logic        cur_write;
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic [2:0]  cur_f3;
    logic [3:0]  cur_size;
    logic [AW-1:0] cur_idx;
    logic        f3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [63:0] raw_rd;
    logic [63:0] ext_rd;

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state_q == IDLE) && !reset;
        busy       = (state_q != IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid && err_q;
    end

    // With LATENCY=0 the accepting edge is also the RESP-entry edge, so the
    // access must be decoded from the live request rather than the latches.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_f3    = req_funct3;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = f3_q;
        end
    end

    always_comb begin
        cur_size     = access_size(cur_f3);
        cur_idx      = cur_addr[AW-1:0];
        f3_bad       = (cur_f3 == F3_BAD) || (cur_write && cur_f3[2]);
        misaligned   = (cur_addr[2:0] & 3'(cur_size - 4'd1)) != 3'd0;
        out_of_range = ({1'b0, cur_addr} + 65'(cur_size)) > 65'(DEPTH_BYTES);
        req_err      = f3_bad || misaligned || out_of_range;
    end

    // Bytes beyond the access size are masked so they never index past the end.
    always_comb begin
        raw_rd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(cur_size)) begin
                raw_rd[8*i +: 8] = mem_q[AW'(32'(cur_idx) + i)];
            end
        end
    end

    load_extend u_load_extend (
        .raw_i    (raw_rd),
        .funct3_i (cur_f3),
        .data_o   (ext_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else begin
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            if (enter_resp) begin
                err_q   <= req_err;
                rdata_q <= (req_err || cur_write) ? '0 : ext_rd;
                if (!req_err && cur_write) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (i < 32'(cur_size)) begin
                            mem_q[AW'(32'(cur_idx) + i)] <= cur_wdata[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: table of load/store vectors against a response
// scoreboard, plus hand-written reset, stall and zero-latency sequences.
module tb_data_mem_responder;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_err, busy;
    logic [63:0] resp_rdata;

    logic        z_valid, z_ready, z_write;
    logic [63:0] z_addr, z_wdata;
    logic [2:0]  z_f3;
    logic        z_resp_valid, z_resp_err, z_busy;
    logic [63:0] z_resp_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_valid),
        .req_ready  (z_ready),
        .req_write  (z_write),
        .req_addr   (z_addr),
        .req_wdata  (z_wdata),
        .req_funct3 (z_f3),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err),
        .busy       (z_busy)
    );

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [2:0]  f;
        logic [63:0] er;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [63:0] rd;
        logic        ee;
        int unsigned cyc;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          nvec = 0;
    int          nmis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                nmis++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rd);
                chk("resp_err", 64'(resp_err), 64'(mon_e.ee));
                chk("resp_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [2:0] f, input logic [63:0] er, input logic ee,
                         input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            nvec++;
            nmis++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
            return;
        end
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        req_valid  = 1'b1;
        if (push) sb_q.push_back('{er, ee, cyc + 1 + LAT});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic z_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [2:0] f, input logic [63:0] er);
        @(negedge clk);
        chk("z_req_ready", 64'(z_ready), 64'd1);
        z_write = w;
        z_addr  = a;
        z_wdata = d;
        z_f3    = f;
        z_valid = 1'b1;
        @(posedge clk);
        #1 z_valid = 1'b0;
        @(negedge clk);
        chk("z_resp_valid", 64'(z_resp_valid), 64'd1);
        chk("z_resp_err", 64'(z_resp_err), 64'd0);
        chk("z_resp_rdata", z_resp_rdata, er);
        @(negedge clk);
        chk("z_resp_valid_drop", 64'(z_resp_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int readies;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        z_valid    = 1'b0;
        z_write    = 1'b0;
        z_addr     = '0;
        z_wdata    = '0;
        z_f3       = '0;

        tbl.push_back('{1'b1, 64'h10,  64'h1122334455667788, 3'b011, 64'h0, 1'b0});
        tbl.push_back('{1'b0, 64'h10,  64'h0, 3'b011, 64'h1122334455667788, 1'b0});
        tbl.push_back('{1'b1, 64'h20,  64'h80, 3'b000, 64'h0, 1'b0});
        tbl.push_back('{1'b0, 64'h20,  64'h0, 3'b000, 64'hFFFFFFFFFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 64'h20,  64'h0, 3'b100, 64'h0000000000000080, 1'b0});
        tbl.push_back('{1'b0, 64'h20,  64'h0, 3'b001, 64'h0000000000000080, 1'b0});
        tbl.push_back('{1'b0, 64'h22,  64'h0, 3'b010, 64'h0, 1'b1});
        tbl.push_back('{1'b1, 64'(DEPTH - 4), 64'hDEADBEEFDEADBEEF, 3'b011, 64'h0, 1'b1});
        tbl.push_back('{1'b0, 64'(DEPTH - 8), 64'h0, 3'b011, 64'h0, 1'b0});
        tbl.push_back('{1'b1, 64'h14,  64'hFFFFFFFF89ABCDEF, 3'b010, 64'h0, 1'b0});
        tbl.push_back('{1'b0, 64'h10,  64'h0, 3'b011, 64'h89ABCDEF55667788, 1'b0});
        tbl.push_back('{1'b0, 64'h14,  64'h0, 3'b010, 64'hFFFFFFFF89ABCDEF, 1'b0});
        tbl.push_back('{1'b0, 64'h14,  64'h0, 3'b110, 64'h0000000089ABCDEF, 1'b0});
        tbl.push_back('{1'b0, 64'h16,  64'h0, 3'b101, 64'h00000000000089AB, 1'b0});
        tbl.push_back('{1'b1, 64'h30,  64'hFF, 3'b100, 64'h0, 1'b1});
        tbl.push_back('{1'b0, 64'h30,  64'h0, 3'b100, 64'h0, 1'b0});
        tbl.push_back('{1'b0, 64'h30,  64'h0, 3'b111, 64'h0, 1'b1});
        tbl.push_back('{1'b1, 64'(DEPTH - 8), 64'hA5A5A5A5A5A5A5A5, 3'b011, 64'h0, 1'b0});
        tbl.push_back('{1'b0, 64'(DEPTH - 1), 64'h0, 3'b100, 64'h00000000000000A5, 1'b0});
        tbl.push_back('{1'b0, 64'(DEPTH - 2), 64'h0, 3'b001, 64'hFFFFFFFFFFFFA5A5, 1'b0});
        tbl.push_back('{1'b0, 64'(DEPTH), 64'h0, 3'b000, 64'h0, 1'b1});
        tbl.push_back('{1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 3'b011, 64'h0, 1'b1});
        tbl.push_back('{1'b1, 64'(DEPTH - 1), 64'h1234, 3'b001, 64'h0, 1'b1});

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, tbl[i].er, tbl[i].ee, 1'b1);
            wait_drain();
        end

        // req_valid held high: one accept every LAT+2 cycles, nothing queued in between
        @(negedge clk);
        req_write  = 1'b0;
        req_addr   = 64'h10;
        req_funct3 = 3'b011;
        req_valid  = 1'b1;
        readies    = 0;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) @(negedge clk);
            chk("stall_busy", 64'(busy), 64'(!req_ready));
            if (req_ready === 1'b1) begin
                readies++;
                sb_q.push_back('{64'h89ABCDEF55667788, 1'b0, cyc + 1 + LAT});
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("stall_ready_pulses", 64'(readies), 64'd3);
        wait_drain();

        // reset one cycle after accepting a store: abandoned, no response
        issue(1'b1, 64'h40, 64'hDEAD, 3'b011, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("after_rst_busy", 64'(busy), 64'd0);
        issue(1'b0, 64'h40, 64'h0, 3'b011, 64'h0, 1'b0, 1'b1);
        wait_drain();
        issue(1'b0, 64'h10, 64'h0, 3'b011, 64'h0, 1'b0, 1'b1);
        wait_drain();

        // zero-latency build
        z_req(1'b1, 64'h8, 64'hCAFEBABE0BADF00D, 3'b011, 64'h0);
        z_req(1'b0, 64'h8, 64'h0, 3'b011, 64'hCAFEBABE0BADF00D);
        z_req(1'b0, 64'hC, 64'h0, 3'b010, 64'hFFFFFFFFCAFEBABE);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 512, meaning the byte capacity of the memory; the value SHALL be a power of two and at least 8.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of wait cycles between request acceptance and response (legal range 0..15).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, exposed on the ports listed first below.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  the load/store request from the processor MEM stage is present.
REQ-007 req_ready  output  1  the block can accept a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data, LSB-aligned.
REQ-011 req_funct3  input  3  RISC-V access size/sign code.
REQ-012 resp_valid  output  1  a one-cycle response pulse.
REQ-013 resp_rdata  output  64  load result after extension; 0 for stores and errors.
REQ-014 resp_err  output  1  the request was rejected (misaligned, out of range or illegal funct3); valid only with resp_valid.
REQ-015 busy  output  1  a request is in flight; the pipeline uses it as a stall.

Function
REQ-016 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; WAIT SHALL be skipped when LATENCY=0.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid&&req_ready at a rising edge, and all req_* fields SHALL be latched at that edge.
REQ-018 WAIT SHALL count LATENCY cycles using a 4-bit counter loaded at acceptance, then transition to RESP.
REQ-019 resp_valid SHALL be 1 for exactly the single RESP cycle, giving a latency of LATENCY+1 cycles from the accepting edge to resp_valid high; there is no response backpressure.
REQ-020 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-021 A store SHALL commit at the edge entering RESP, writing 1/2/4/8 bytes little-endian for funct3 000/001/010/011.
REQ-022 Loads SHALL read at the edge entering RESP; funct3 000 lb, 001 lh, 010 lw and 011 ld SHALL sign-extend; 100 lbu, 101 lhu and 110 lwu SHALL zero-extend.
REQ-023 Stores with funct3 1xx, and any access with funct3 111, SHALL produce resp_err=1.
REQ-024 Misaligned addresses (addr not a multiple of the access size) SHALL produce resp_err=1.
REQ-025 An access with addr+size > DEPTH_BYTES SHALL produce resp_err=1; no wrap-around.
REQ-026 An errored request SHALL perform no memory write and SHALL return resp_rdata=0.
REQ-027 req_valid asserted during WAIT or RESP SHALL be ignored and not queued.
REQ-028 Back-to-back requests SHALL be accepted no earlier than the cycle after RESP, i.e. with a throughput of one request per LATENCY+2 cycles.
REQ-029 A load issued after a store to the same address SHALL return the newly stored data.

Reset
REQ-030 Reset SHALL force state IDLE, counter 0, latched request fields 0, req_ready 0 while reset is asserted and 1 after it is released, resp_valid 0, resp_rdata 0, resp_err 0 and busy 0.
REQ-031 Reset SHALL clear every memory byte to 0.
REQ-032 Reset asserted during WAIT SHALL abandon the request, with no write and no response; reset asserted during RESP SHALL suppress resp_valid immediately.

Structure
REQ-033 Shared package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP), the funct3 encoding constants and the access-size function.
REQ-034 A single sub-module, load_extend (combinational: raw 64-bit read, funct3 -> extended result), SHALL be instantiated once.

Verification
REQ-035 LATENCY=2: store funct3=011, addr 0x10, data 0x1122334455667788, then load ld from 0x10 -> resp_rdata 0x1122334455667788, resp_err 0, with resp_valid 3 cycles after each acceptance.
REQ-036 After sb of 0x80 to 0x20: lb 0x20 -> 0xFFFFFFFFFFFFFF80; lbu 0x20 -> 0x0000000000000080; lh 0x20 -> 0x0000000000000080.
REQ-037 lw from addr 0x22 -> resp_err 1, rdata 0; sd to DEPTH_BYTES-4 -> resp_err 1, and a subsequent ld of DEPTH_BYTES-8 returns 0.
REQ-038 req_valid held high continuously -> req_ready pulses once every LATENCY+2 cycles, busy is high in between, and no request is lost or duplicated.
REQ-039 Reset asserted one cycle after accepting sd 0xDEAD to 0x40 -> no resp_valid; a following ld of 0x40 returns 0.
REQ-040 LATENCY=0 build: store then load of the same address -> resp_valid on the cycle after each acceptance, with correct data.
